// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: geometry, state encoding
// and the fetch anti-starvation threshold.
package imem_arbiter_pkg;

  localparam int unsigned ADDR_W       = 16;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned DEPTH        = 2048;
  localparam int unsigned STARVE_MAX   = 4;
  localparam int unsigned STARVE_CNT_W = 3;

  // Each state mirrors the grant issued in the previous cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Counts consecutive cycles in which a pending fetch loses arbitration and flags
// when the fetch port must win the next contention. Only built with
// IMEM_ARB_STARVE_EN defined.
module imem_arb_starve_ctr #(
  parameter int unsigned STARVE_MAX = imem_arbiter_pkg::STARVE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic fetch_req,
  input  logic fetch_gnt,
  output logic starved_c
);
  import imem_arbiter_pkg::*;

  localparam int unsigned CNT_W = STARVE_CNT_W;

  logic [CNT_W-1:0] cnt_q;

  // Loss counter: clears on a fetch grant or an idle fetch port, saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!fetch_req || fetch_gnt) begin
      cnt_q <= '0;
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Fetch gets priority once the loss budget is spent.
  assign starved_c = (cnt_q >= CNT_W'(STARVE_MAX));

endmodule

// File: rtl/imem_arbiter.sv
// Two-port arbiter in front of a single-port instruction memory: a fetch (read)
// port and a loader (write) port. Loader has priority; optional fetch
// anti-starvation is enabled by defining IMEM_ARB_STARVE_EN.
module imem_arbiter #(
  parameter int unsigned ADDR_W     = imem_arbiter_pkg::ADDR_W,
  parameter int unsigned DATA_W     = imem_arbiter_pkg::DATA_W,
  parameter int unsigned DEPTH      = imem_arbiter_pkg::DEPTH
`ifdef IMEM_ARB_STARVE_EN
  ,
  parameter int unsigned STARVE_MAX = imem_arbiter_pkg::STARVE_MAX
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  output logic              fetch_err,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_wdata,
  output logic              load_gnt,
  output logic              mem_rd,
  output logic              mem_wn,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);
  import imem_arbiter_pkg::*;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       fetch_err_q;
  logic       starved_c;

`ifdef IMEM_ARB_STARVE_EN
  imem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk       (clk),
    .rst       (rst),
    .fetch_req (fetch_req),
    .fetch_gnt (fetch_gnt),
    .starved_c (starved_c)
  );
`else
  assign starved_c = 1'b0;
`endif

  // State register: remembers last cycle's grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Out-of-range flag for the fetch whose response is due next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_err_q <= 1'b0;
    end else if (fetch_gnt) begin
      fetch_err_q <= (fetch_addr >= DEPTH_A);
    end
  end

  // Next state follows the grant taken this cycle.
  always_comb begin
    state_d = IDLE;
    if (fetch_gnt) begin
      state_d = FETCH;
    end else if (load_gnt) begin
      state_d = LOAD;
    end
  end

  // Arbitration, memory strobes and the read response seen by the fetch port.
  always_comb begin
    fetch_gnt      = 1'b0;
    load_gnt       = 1'b0;
    mem_rd         = 1'b0;
    mem_wn         = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (!rst) begin
      if (fetch_req && (!load_req || starved_c)) begin
        fetch_gnt = 1'b1;
      end else if (load_req) begin
        load_gnt = 1'b1;
      end
    end
    // Out-of-range transfers are granted but never reach the memory.
    if (fetch_gnt && (fetch_addr < DEPTH_A)) begin
      mem_rd      = 1'b1;
      mem_address = fetch_addr;
    end
    if (load_gnt && (load_addr < DEPTH_A)) begin
      mem_wn         = 1'b1;
      mem_address    = load_addr;
      mem_write_data = load_wdata;
    end
    fetch_rvalid = (state_q == FETCH);
    fetch_err    = fetch_rvalid && fetch_err_q;
    fetch_rdata  = (fetch_rvalid && !fetch_err_q) ? mem_read_data : '0;
    busy         = fetch_gnt || load_gnt || (state_q == FETCH);
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: a memory model, a cycle-level reference model with
// per-cycle comparison, and directed scenarios with literal expectations.
module tb_imem_arbiter;
  import imem_arbiter_pkg::*;

`ifdef IMEM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        fetch_err;
  logic        load_req;
  logic [15:0] load_addr;
  logic [31:0] load_wdata;
  logic        load_gnt;
  logic        mem_rd;
  logic        mem_wn;
  logic [15:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        busy;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  imem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_req      (fetch_req),
    .fetch_addr     (fetch_addr),
    .fetch_gnt      (fetch_gnt),
    .fetch_rvalid   (fetch_rvalid),
    .fetch_rdata    (fetch_rdata),
    .fetch_err      (fetch_err),
    .load_req       (load_req),
    .load_addr      (load_addr),
    .load_wdata     (load_wdata),
    .load_gnt       (load_gnt),
    .mem_rd         (mem_rd),
    .mem_wn         (mem_wn),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int a);
    return (a == 5) ? 32'hDEADBEEF : (32'hA000_0000 | 32'(a));
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory with a registered read port; strobes captured mid-cycle, applied at the edge.
  logic [31:0] mem [0:2047];
  initial begin
    logic        c_rd, c_wn;
    logic [15:0] c_a;
    logic [31:0] c_d;
    for (int i = 0; i < 2048; i++) mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      c_rd = mem_rd; c_wn = mem_wn; c_a = mem_address; c_d = mem_write_data;
      @(posedge clk);
      if (c_wn) mem[c_a[10:0]] = c_d;
      if (c_rd) mem_read_data <= mem[c_a[10:0]];
    end
  end

  // Reference model and per-cycle compare.
  logic [31:0] shadow [0:2047];
  initial begin
    bit          pv, pe;
    logic [31:0] pd;
    int          losses;
    bit          efg, elg, f_in, l_in, erd, ewn, erv;
    logic [15:0] ea;
    logic [31:0] ed, er;
    for (int i = 0; i < 2048; i++) shadow[i] = init_word(i);
    pv = 1'b0; pe = 1'b0; pd = '0; losses = 0;
    forever begin
      @(negedge clk);
      f_in = (fetch_addr < 16'd2048);
      l_in = (load_addr < 16'd2048);
      if (rst) begin
        efg = 1'b0; elg = 1'b0;
      end else begin
        efg = fetch_req && (!load_req || (STARVE_EN && losses >= int'(STARVE_MAX)));
        elg = load_req && !efg;
      end
      erd = efg && f_in;
      ewn = elg && l_in;
      ea  = erd ? fetch_addr : (ewn ? load_addr : 16'h0);
      ed  = ewn ? load_wdata : 32'h0;
      erv = !rst && pv;
      er  = (erv && !pe) ? pd : 32'h0;
      chk1 ("model fetch_gnt", fetch_gnt, efg);
      chk1 ("model load_gnt", load_gnt, elg);
      chk1 ("model mem_rd", mem_rd, erd);
      chk1 ("model mem_wn", mem_wn, ewn);
      chk1 ("model rd_and_wn", mem_rd & mem_wn, 1'b0);
      chk32("model mem_address", 32'(mem_address), 32'(ea));
      chk32("model mem_write_data", mem_write_data, ed);
      chk1 ("model fetch_rvalid", fetch_rvalid, erv);
      chk1 ("model fetch_err", fetch_err, erv && pe);
      chk32("model fetch_rdata", fetch_rdata, er);
      chk1 ("model busy", busy, efg || elg || erv);
      if (rst) begin
        pv = 1'b0; losses = 0;
      end else begin
        pv = efg;
        pe = !f_in;
        pd = f_in ? shadow[fetch_addr[10:0]] : 32'h0;
        if (ewn) shadow[load_addr[10:0]] = load_wdata;
        if (!fetch_req || efg) losses = 0;
        else losses++;
      end
    end
  end

  task automatic set_in(input bit fr, input logic [15:0] fa,
                        input bit lr, input logic [15:0] la, input logic [31:0] ld);
    fetch_req = fr; fetch_addr = fa; load_req = lr; load_addr = la; load_wdata = ld;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_in(1'b1, 16'h0005, 1'b0, 16'h0, 32'h0);
    // Reset holds every output low even with a request present.
    @(negedge clk);
    chk1("reset fetch_gnt", fetch_gnt, 1'b0);
    chk1("reset mem_rd", mem_rd, 1'b0);
    chk1("reset busy", busy, 1'b0);
    chk1("reset fetch_rvalid", fetch_rvalid, 1'b0);
    adv(); adv();
    rst = 1'b0;

    // Basic fetch: grant now, data next cycle.
    @(negedge clk);
    chk1 ("s1 fetch_gnt", fetch_gnt, 1'b1);
    chk1 ("s1 mem_rd", mem_rd, 1'b1);
    chk32("s1 mem_address", 32'(mem_address), 32'h5);
    adv();
    set_in(1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    chk1 ("s1 fetch_rvalid", fetch_rvalid, 1'b1);
    chk32("s1 fetch_rdata", fetch_rdata, 32'hDEADBEEF);
    chk1 ("s1 fetch_err", fetch_err, 1'b0);
    adv();

    // Contention: loader first, then fetch reads the freshly written word.
    set_in(1'b1, 16'h0010, 1'b1, 16'h0010, 32'h12345678);
    @(negedge clk);
    chk1("s2 load_gnt", load_gnt, 1'b1);
    chk1("s2 fetch_gnt", fetch_gnt, 1'b0);
    chk1("s2 mem_wn", mem_wn, 1'b1);
    adv();
    set_in(1'b1, 16'h0010, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    chk1("s2 fetch_gnt late", fetch_gnt, 1'b1);
    adv();
    set_in(1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    chk1 ("s2 fetch_rvalid", fetch_rvalid, 1'b1);
    chk32("s2 fetch_rdata", fetch_rdata, 32'h12345678);
    adv();

    // Out-of-range fetch, then out-of-range load in the very next cycle.
    set_in(1'b1, 16'h0800, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    chk1("s3 fetch_gnt", fetch_gnt, 1'b1);
    chk1("s3 mem_rd", mem_rd, 1'b0);
    adv();
    set_in(1'b0, 16'h0, 1'b1, 16'h0FFF, 32'hCAFEF00D);
    @(negedge clk);
    chk1 ("s3 fetch_rvalid", fetch_rvalid, 1'b1);
    chk1 ("s3 fetch_err", fetch_err, 1'b1);
    chk32("s3 fetch_rdata", fetch_rdata, 32'h0);
    chk1 ("s3 load_gnt", load_gnt, 1'b1);
    chk1 ("s3 mem_wn", mem_wn, 1'b0);
    adv();
    set_in(1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    adv();

    // Starvation: both held; fetch wins the 5th contended cycle only when enabled.
    set_in(1'b1, 16'h0020, 1'b1, 16'h0030, 32'h5555AAAA);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk1($sformatf("s4 fetch_gnt cycle %0d", k), fetch_gnt, STARVE_EN && (k == 5));
      chk1($sformatf("s4 load_gnt cycle %0d", k), load_gnt, !(STARVE_EN && (k == 5)));
      adv();
    end
    set_in(1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    adv();

    // Reset right after a fetch grant cancels the response.
    set_in(1'b1, 16'h0003, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    chk1("s5 fetch_gnt", fetch_gnt, 1'b1);
    adv();
    rst = 1'b1;
    set_in(1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    chk1("s5 rvalid in reset", fetch_rvalid, 1'b0);
    chk1("s5 busy in reset", busy, 1'b0);
    adv();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1($sformatf("s5 rvalid after release %0d", k), fetch_rvalid, 1'b0);
      adv();
    end

    // Streaming: eight back-to-back fetches, one response per cycle in order.
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) set_in(1'b1, 16'(i), 1'b0, 16'h0, 32'h0);
      else       set_in(1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
      @(negedge clk);
      if (i < 8) chk1($sformatf("s6 fetch_gnt %0d", i), fetch_gnt, 1'b1);
      if (i > 0) begin
        chk1 ($sformatf("s6 rvalid %0d", i - 1), fetch_rvalid, 1'b1);
        chk32($sformatf("s6 rdata %0d", i - 1), fetch_rdata, init_word(i - 1));
      end
      adv();
    end
    @(negedge clk);
    chk1("s6 rvalid drained", fetch_rvalid, 1'b0);
    adv();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 16, word address width; DATA_W, 32, instruction width; DEPTH, 2048, memory words; STARVE_MAX, 4, consecutive fetch losses before a forced fetch grant.
REQ-002 Ports SHALL be (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- fetch_req  in  1  fetch port requests a read
- fetch_addr  in  ADDR_W  fetch word address
- fetch_gnt  out  1  fetch request accepted this cycle
- fetch_rvalid  out  1  fetch_rdata valid
- fetch_rdata  out  DATA_W  read data
- fetch_err  out  1  with fetch_rvalid: address was out of range
- load_req  in  1  loader port requests a write
- load_addr  in  ADDR_W  loader word address
- load_wdata  in  DATA_W  loader write data
- load_gnt  out  1  write accepted this cycle
- mem_rd  out  1  memory read strobe
- mem_wn  out  1  memory write strobe
- mem_address  out  ADDR_W  memory address
- mem_write_data  out  DATA_W  memory write data
- mem_read_data  in  DATA_W  memory read data, registered, valid one cycle after mem_rd
- busy  out  1  a grant or a read response is in flight

Function
REQ-003 Grants, mem_rd, mem_wn, mem_address and mem_write_data SHALL be combinational from the current requests and registered arbiter state; at most one grant per cycle.
REQ-004 mem_rd and mem_wn SHALL never be high together; with no grant, both SHALL be 0 and mem_address/mem_write_data SHALL be 0.
REQ-005 A request SHALL be held with stable address/data until its grant; a grant completes the transfer in that cycle.
REQ-006 Default priority SHALL be the loader: load_req high wins over fetch_req.
REQ-007 A fetch granted in cycle N SHALL produce fetch_rvalid=1 and fetch_rdata=mem_read_data in cycle N+1, exactly one cycle.
REQ-008 Back-to-back fetch grants SHALL be allowed every cycle, giving one rvalid per cycle.
REQ-009 A granted fetch or load with address >= DEPTH SHALL NOT strobe the memory. A fetch SHALL return fetch_rvalid=1, fetch_err=1 and fetch_rdata=0 in N+1; a load SHALL be granted and dropped.
REQ-010 The FSM SHALL have the states IDLE, FETCH and LOAD, each reflecting last cycle's grant. IDLE is entered on a cycle with no grant. FETCH is entered on a fetch grant and drives rvalid next cycle. LOAD is entered on a load grant.
REQ-011 A load grant in the cycle after a fetch grant SHALL be permitted, because the read response comes from the memory's output register.
REQ-012 busy SHALL equal any grant OR the state being FETCH.

Reset
REQ-013 While rst is high, all outputs SHALL be 0, the state SHALL be IDLE and the starvation counter SHALL be 0.
REQ-014 A reset asserted in the cycle after a fetch grant SHALL cancel the pending fetch_rvalid; no response SHALL appear after release.
REQ-015 The first grant SHALL be possible in the first clock edge after rst deasserts.

Configuration
REQ-016 Macro IMEM_ARB_STARVE_EN SHALL control fetch anti-starvation.
- Defined: a 3-bit counter SHALL count consecutive cycles in which fetch_req=1 and is not granted. When the count reaches STARVE_MAX, fetch SHALL win the next contention, and the counter SHALL clear on any fetch grant or when fetch_req=0.
- Undefined: no counter SHALL exist and strict loader priority SHALL apply.

Structure
REQ-017 A shared package SHALL hold ADDR_W, DATA_W, DEPTH, the state enum (IDLE, FETCH, LOAD) and the STARVE_MAX default.
REQ-018 One sub-module, imem_arb_starve_ctr, SHALL contain the starvation counter and SHALL be instantiated only under IMEM_ARB_STARVE_EN.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset, fetch_req=1 at 0x0005 with memory preloaded 0xDEADBEEF: fetch_gnt in cycle N, then fetch_rvalid=1 and fetch_rdata=0xDEADBEEF in N+1, fetch_err=0.
- Simultaneous load_req (0x0010, 0x12345678) and fetch_req (0x0010): load_gnt first, fetch next cycle, then rdata=0x12345678.
- fetch_addr=0x0800: no mem_rd, then fetch_rvalid=1, fetch_err=1, rdata=0; load_addr=0x0FFF: load_gnt=1 with mem_wn=0.
- Starvation with the macro defined: load_req held and fetch_req held. Fetch is granted on the 5th contended cycle (after 4 losses); without the macro, fetch is never granted while load_req is high.
- Reset mid-fetch: fetch granted, rst high in the next cycle gives fetch_rvalid=0, and no response appears after release.
- Streaming: 8 consecutive fetches to 0..7 give 8 consecutive rvalids in order, and mem_rd&mem_wn=0 in every cycle.
